// File: rtl/memory_requester_if.sv
// Host command/response and memory_control handshake signals grouped for memory_requester.
// The slave view belongs to the requester; the master view belongs to whatever drives it.
interface memory_requester_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_data;

    logic              resp_valid;
    logic              resp_ack;
    logic [DATA_W-1:0] resp_data;
    logic              resp_error;

    logic              mem_unlock;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_buffer;
    logic              mem_ready;

    modport slave (
        input  cmd_valid, cmd_write, cmd_address, cmd_data,
        input  resp_ack,
        input  mem_buffer, mem_ready,
        output cmd_ready,
        output resp_valid, resp_data, resp_error,
        output mem_unlock, mem_write, mem_address, mem_data
    );

    modport master (
        output cmd_valid, cmd_write, cmd_address, cmd_data,
        output resp_ack,
        output mem_buffer, mem_ready,
        input  cmd_ready,
        input  resp_valid, resp_data, resp_error,
        input  mem_unlock, mem_write, mem_address, mem_data
    );
endinterface

// File: rtl/memory_requester.sv
// Initiator for memory_control: takes one host command at a time, strobes the controller,
// waits for ready with a timeout and holds the response until the host acknowledges it.
module memory_requester #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 16,
    parameter int UNLOCK_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                clock,
    input  logic                reset,
    memory_requester_if.slave   bus,
    output logic [15:0]         txn_count,
    output logic [7:0]          err_count
);

    localparam int ISSUE_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(TIMEOUT);
    localparam logic [ISSUE_W-1:0] ISSUE_LAST = ISSUE_W'(UNLOCK_CYCLES - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t              state_reg,       state_next;
    logic [ISSUE_W-1:0]  issue_cnt_reg,   issue_cnt_next;
    logic [WAIT_W-1:0]   wait_cnt_reg,    wait_cnt_next;
    logic                cmd_ready_reg,   cmd_ready_next;
    logic                mem_unlock_reg,  mem_unlock_next;
    logic                mem_write_reg,   mem_write_next;
    logic [ADDR_W-1:0]   mem_address_reg, mem_address_next;
    logic [DATA_W-1:0]   mem_data_reg,    mem_data_next;
    logic                resp_valid_reg,  resp_valid_next;
    logic [DATA_W-1:0]   resp_data_reg,   resp_data_next;
    logic                resp_error_reg,  resp_error_next;
    logic [15:0]         txn_count_reg,   txn_count_next;
    logic [7:0]          err_count_reg,   err_count_next;

    logic                accept;
    logic                issue_done;
    logic                wait_hit;
    logic                wait_expired;
    logic                ack;
    logic [DATA_W-1:0]   read_word;

    assign accept       = (state_reg == S_IDLE) && cmd_ready_reg && bus.cmd_valid;
    assign issue_done   = (state_reg == S_ISSUE) && (issue_cnt_reg == ISSUE_LAST);
    assign wait_hit     = (state_reg == S_WAIT) && bus.mem_ready;
    // A ready on the last counted cycle is a completion, never a timeout.
    assign wait_expired = (state_reg == S_WAIT) && !bus.mem_ready && (wait_cnt_reg == WAIT_LAST);
    assign ack          = (state_reg == S_RESPOND) && bus.resp_ack;

    // Writes return a zero word; reads return whatever the controller presents.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_read_word
            assign read_word[gi] = bus.mem_buffer[gi] & ~mem_write_reg;
        end
    endgenerate

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            issue_cnt_reg   <= '0;
            wait_cnt_reg    <= '0;
            cmd_ready_reg   <= 1'b0;
            mem_unlock_reg  <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= '0;
            resp_error_reg  <= 1'b0;
            txn_count_reg   <= '0;
            err_count_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            issue_cnt_reg   <= issue_cnt_next;
            wait_cnt_reg    <= wait_cnt_next;
            cmd_ready_reg   <= cmd_ready_next;
            mem_unlock_reg  <= mem_unlock_next;
            mem_write_reg   <= mem_write_next;
            mem_address_reg <= mem_address_next;
            mem_data_reg    <= mem_data_next;
            resp_valid_reg  <= resp_valid_next;
            resp_data_reg   <= resp_data_next;
            resp_error_reg  <= resp_error_next;
            txn_count_reg   <= txn_count_next;
            err_count_reg   <= err_count_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:    if (accept)                   state_next = S_ISSUE;
            S_ISSUE:   if (issue_done)               state_next = S_WAIT;
            S_WAIT:    if (wait_hit || wait_expired) state_next = S_RESPOND;
            S_RESPOND: if (ack)                      state_next = S_IDLE;
            default:                                 state_next = S_IDLE;
        endcase
    end

    // Next values of every registered output and counter
    always_comb begin
        issue_cnt_next   = issue_cnt_reg;
        wait_cnt_next    = wait_cnt_reg;
        cmd_ready_next   = cmd_ready_reg;
        mem_unlock_next  = mem_unlock_reg;
        mem_write_next   = mem_write_reg;
        mem_address_next = mem_address_reg;
        mem_data_next    = mem_data_reg;
        resp_valid_next  = resp_valid_reg;
        resp_data_next   = resp_data_reg;
        resp_error_next  = resp_error_reg;
        txn_count_next   = txn_count_reg;
        err_count_next   = err_count_reg;

        unique case (state_reg)
            S_IDLE: begin
                cmd_ready_next = !accept;
                if (accept) begin
                    mem_unlock_next  = 1'b1;
                    mem_write_next   = bus.cmd_write;
                    mem_address_next = bus.cmd_address;
                    mem_data_next    = bus.cmd_data;
                    issue_cnt_next   = '0;
                end
            end
            S_ISSUE: begin
                // mem_ready seen here belongs to an earlier cycle and is ignored.
                if (issue_done) begin
                    mem_unlock_next = 1'b0;
                    wait_cnt_next   = '0;
                end else begin
                    issue_cnt_next = issue_cnt_reg + ISSUE_W'(1);
                end
            end
            S_WAIT: begin
                if (wait_hit) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = read_word;
                    resp_error_next = 1'b0;
                    txn_count_next  = txn_count_reg + 16'd1;
                end else if (wait_expired) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = '0;
                    resp_error_next = 1'b1;
                    txn_count_next  = txn_count_reg + 16'd1;
                    if (err_count_reg != 8'hFF) begin
                        err_count_next = err_count_reg + 8'd1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            S_RESPOND: begin
                if (ack) begin
                    resp_valid_next  = 1'b0;
                    resp_data_next   = '0;
                    resp_error_next  = 1'b0;
                    cmd_ready_next   = 1'b1;
                    mem_write_next   = 1'b0;
                    mem_address_next = '0;
                    mem_data_next    = '0;
                end
            end
            default: begin
                cmd_ready_next = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready   = cmd_ready_reg;
    assign bus.mem_unlock  = mem_unlock_reg;
    assign bus.mem_write   = mem_write_reg;
    assign bus.mem_address = mem_address_reg;
    assign bus.mem_data    = mem_data_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_data   = resp_data_reg;
    assign bus.resp_error  = resp_error_reg;
    assign txn_count       = txn_count_reg;
    assign err_count       = err_count_reg;

endmodule

// File: tb/tb_memory_requester.sv
// Directed bench for memory_requester: the bench plays host and memory_control, and a
// cycle-indexed transaction model is compared against the outputs on every falling edge.
module tb_memory_requester;

    localparam int ADDR_W        = 10;
    localparam int DATA_W        = 16;
    localparam int UNLOCK_CYCLES = 2;
    localparam int TIMEOUT       = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    int tests_run    = 0;
    int tests_failed = 0;

    memory_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    memory_requester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .UNLOCK_CYCLES(UNLOCK_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .txn_count(txn_count),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // A transaction is indexed by cycles since its accept edge: cycles 1..UNLOCK_CYCLES strobe
    // the controller, cycles after that are WAIT cycles 1..TIMEOUT.
    bit                m_live = 0;
    bit                m_busy = 0;
    bit                m_resp = 0;
    int                m_age  = 0;
    int                m_last_wait = 0;
    logic              e_cmd_ready = 0, e_unlock = 0, e_write = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_data = '0;
    logic              e_resp_valid = 0, e_resp_error = 0;
    logic [DATA_W-1:0] e_resp_data = '0;
    logic [15:0]       e_txn = '0;
    logic [7:0]        e_err = '0;

    task model_finish(input logic [DATA_W-1:0] word, input logic err);
        m_busy       = 0;
        m_resp       = 1;
        m_last_wait  = m_age - UNLOCK_CYCLES;
        e_resp_valid = 1;
        e_resp_data  = word;
        e_resp_error = err;
        e_txn        = e_txn + 16'd1;
        if (err && e_err != 8'hFF) e_err = e_err + 8'd1;
    endtask

    task model_step();
        m_live = 1;
        if (reset) begin
            m_busy = 0; m_resp = 0;
            e_cmd_ready = 0; e_unlock = 0; e_write = 0; e_addr = '0; e_data = '0;
            e_resp_valid = 0; e_resp_error = 0; e_resp_data = '0; e_txn = '0; e_err = '0;
        end else if (m_resp) begin
            if (bus.resp_ack) begin
                m_resp = 0;
                e_resp_valid = 0; e_resp_data = '0; e_resp_error = 0;
                e_cmd_ready = 1; e_write = 0; e_addr = '0; e_data = '0;
            end
        end else if (m_busy) begin
            m_age++;
            if (m_age <= UNLOCK_CYCLES)
                e_unlock = (m_age < UNLOCK_CYCLES);
            else if (bus.mem_ready)
                model_finish(e_write ? '0 : bus.mem_buffer, 1'b0);
            else if (m_age - UNLOCK_CYCLES == TIMEOUT)
                model_finish('0, 1'b1);
        end else if (e_cmd_ready && bus.cmd_valid) begin
            m_busy = 1; m_age = 0;
            e_cmd_ready = 0; e_unlock = 1;
            e_write = bus.cmd_write; e_addr = bus.cmd_address; e_data = bus.cmd_data;
        end else begin
            e_cmd_ready = 1;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    logic prev_resp_valid = 0;
    initial forever begin
        @(negedge clock);
        if (m_live) begin
            check("cmd_ready",  32'(bus.cmd_ready),  32'(e_cmd_ready));
            check("mem_unlock", 32'(bus.mem_unlock), 32'(e_unlock));
            check("resp_valid", 32'(bus.resp_valid), 32'(e_resp_valid));
            check("txn_count",  32'(txn_count),      32'(e_txn));
            check("err_count",  32'(err_count),      32'(e_err));
            if (!m_resp) begin
                check("mem_write",   32'(bus.mem_write),   32'(e_write));
                check("mem_address", 32'(bus.mem_address), 32'(e_addr));
                check("mem_data",    32'(bus.mem_data),    32'(e_data));
            end
            if (e_resp_valid) begin
                check("resp_data",  32'(bus.resp_data),  32'(e_resp_data));
                check("resp_error", 32'(bus.resp_error), 32'(e_resp_error));
            end
            if (bus.resp_valid && !prev_resp_valid)
                $display("[TB] txn %0d: %s addr=0x%03h wdata=0x%04h -> rdata=0x%04h error=%0d waits=%0d",
                         txn_count, e_write ? "write" : "read ", e_addr, e_data,
                         bus.resp_data, bus.resp_error, m_last_wait);
            prev_resp_valid = bus.resp_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_address = a; bus.cmd_data = d;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 200) begin
            tests_failed++;
            $display("FAIL cmd_accept: cmd_ready still 0 after %0d cycles, expected 1", n);
        end
        tick();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_address = '0; bus.cmd_data = '0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (n >= 200) begin
            tests_failed++;
            $display("FAIL resp_wait: resp_valid still 0 after %0d cycles, expected 1", n);
        end
    endtask

    task automatic ack_resp();
        bus.resp_ack = 1;
        tick();
        bus.resp_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n;
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_address = '0; bus.cmd_data = '0;
        bus.resp_ack = 0; bus.mem_buffer = '0; bus.mem_ready = 0;

        repeat (3) tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        reset = 0;
        tick();
        check("rst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset while waiting on the controller
        send_cmd(1'b0, 10'h0AA, 16'h0000);
        repeat (UNLOCK_CYCLES + 4) tick();
        check("wait_addr_stable", 32'(bus.mem_address), 32'h0AA);
        reset = 1;
        tick();
        check("rst_wait_unlock",  32'(bus.mem_unlock),  32'd0);
        check("rst_wait_address", 32'(bus.mem_address), 32'd0);
        check("rst_wait_ready",   32'(bus.cmd_ready),   32'd0);
        check("rst_wait_resp",    32'(bus.resp_valid),  32'd0);
        reset = 0;
        tick();
        check("rst_wait_release", 32'(bus.cmd_ready), 32'd1);

        // Write 0x005/0xBEEF, ready on WAIT cycle 8
        send_cmd(1'b1, 10'h005, 16'hBEEF);
        check("wr_unlock_c1", 32'(bus.mem_unlock), 32'd1);
        check("wr_mem_write", 32'(bus.mem_write),  32'd1);
        check("wr_mem_data",  32'(bus.mem_data),   32'hBEEF);
        check("wr_mem_addr",  32'(bus.mem_address), 32'h005);
        tick();
        check("wr_unlock_c2", 32'(bus.mem_unlock), 32'd1);
        tick();
        check("wr_unlock_c3", 32'(bus.mem_unlock), 32'd0);
        repeat (7) tick();
        bus.mem_ready = 1; bus.mem_buffer = 16'hAAAA;
        tick();
        bus.mem_ready = 0;
        check("wr_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("wr_resp_data",  32'(bus.resp_data),  32'd0);
        check("wr_resp_error", 32'(bus.resp_error), 32'd0);
        check("wr_txn_count",  32'(txn_count),      32'd1);
        ack_resp();
        check("wr_after_ack_ready", 32'(bus.cmd_ready), 32'd1);

        // Read 0x3FF returning 0x1234, held five cycles without ack
        send_cmd(1'b0, 10'h3FF, 16'h0000);
        repeat (UNLOCK_CYCLES) tick();
        bus.mem_ready = 1; bus.mem_buffer = 16'h1234;
        tick();
        bus.mem_ready = 0; bus.mem_buffer = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_valid", 32'(bus.resp_valid), 32'd1);
            check("rd_hold_data",  32'(bus.resp_data),  32'h1234);
            check("rd_hold_error", 32'(bus.resp_error), 32'd0);
            tick();
        end
        ack_resp();
        check("rd_txn_count", 32'(txn_count), 32'd2);

        // Controller never answers: 64 WAIT cycles then an error response
        bus.mem_buffer = 16'hDEAD;
        send_cmd(1'b0, 10'h100, 16'h0000);
        repeat (UNLOCK_CYCLES) tick();
        wait_resp(n);
        check("to_wait_cycles",  32'(n),              32'd64);
        check("to_model_waits",  32'(m_last_wait),    32'd64);
        check("to_resp_error",   32'(bus.resp_error), 32'd1);
        check("to_resp_data",    32'(bus.resp_data),  32'd0);
        check("to_err_count",    32'(err_count),      32'd1);
        check("to_txn_count",    32'(txn_count),      32'd3);
        ack_resp();

        // Stale ready through ISSUE, real ready on WAIT cycle 3
        bus.mem_ready = 1; bus.mem_buffer = 16'h0BAD;
        send_cmd(1'b0, 10'h155, 16'h0000);
        tick();
        tick();
        bus.mem_ready = 0;
        check("stale_w1", 32'(bus.resp_valid), 32'd0);
        tick();
        check("stale_w2", 32'(bus.resp_valid), 32'd0);
        tick();
        bus.mem_ready = 1; bus.mem_buffer = 16'h5A5A;
        check("stale_w3", 32'(bus.resp_valid), 32'd0);
        tick();
        bus.mem_ready = 0;
        check("stale_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("stale_resp_data",  32'(bus.resp_data),  32'h5A5A);
        check("stale_model_wait", 32'(m_last_wait),    32'd3);
        ack_resp();

        // txn_count wrap and back-to-back command held through RESPOND
        force dut.txn_count_reg = 16'hFFFF;
        e_txn = 16'hFFFF;
        tick();
        release dut.txn_count_reg;
        send_cmd(1'b1, 10'h02A, 16'h0F0F);
        repeat (UNLOCK_CYCLES) tick();
        bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        check("wrap_txn_count", 32'(txn_count), 32'h0000);
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_address = 10'h3C1; bus.cmd_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            check("respond_no_accept", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        ack_resp();
        check("b2b_idle_ready", 32'(bus.cmd_ready),   32'd1);
        check("b2b_idle_addr",  32'(bus.mem_address), 32'd0);
        tick();
        bus.cmd_valid = 0; bus.cmd_address = '0;
        check("b2b_accept_ready",  32'(bus.cmd_ready),   32'd0);
        check("b2b_accept_unlock", 32'(bus.mem_unlock),  32'd1);
        check("b2b_accept_addr",   32'(bus.mem_address), 32'h3C1);
        repeat (UNLOCK_CYCLES) tick();
        bus.mem_ready = 1; bus.mem_buffer = 16'h7777;
        tick();
        bus.mem_ready = 0;
        check("b2b_resp_data", 32'(bus.resp_data), 32'h7777);
        check("b2b_txn_count", 32'(txn_count),     32'd1);
        ack_resp();

        // err_count saturation: 254 more timeouts reach 0xFF, one further stays there
        bus.mem_buffer = 16'h0000;
        for (int i = 0; i < 255; i++) begin
            send_cmd(1'b0, ADDR_W'(i), 16'h0000);
            wait_resp(n);
            if (i == 253) check("sat_err_count_ff", 32'(err_count), 32'hFF);
            ack_resp();
        end
        check("sat_err_count_held", 32'(err_count), 32'hFF);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
